carry_chain_pipe: RTL and testbench

CARRY_CHAIN_PIPE -- requirements
Module: carry_chain_pipe

---
 rtl/carry_chain_pkg.sv | 25 ++
 rtl/carry_chain_stage.sv | 80 ++++++++
 rtl/carry_chain_pipe.sv | 86 ++++++++
 tb/tb_carry_chain_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/carry_chain_pkg.sv
// carry_chain_pkg
//   Shared types and helpers for the pipelined carry chain.
//   - MAX_WIDTH       : widest chain the payload struct can hold
//   - stage_payload_t : what travels between pipeline stages
//       g, p   : per-bit generate/propagate (bits beyond WIDTH stay 0)
//       carry  : carry into each bit; filled in segment by segment
//       cin    : running carry into the next unprocessed bit
//                (after the last stage this is the chain carry-out)
//   - seg_width()     : bits evaluated per stage
package carry_chain_pkg;

    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] g;
        logic [MAX_WIDTH-1:0] p;
        logic [MAX_WIDTH-1:0] carry;
        logic                 cin;
    } stage_payload_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/carry_chain_stage.sv
// carry_chain_stage
//   One pipeline segment: ripples SEG bits of the carry chain starting at
//   bit BASE, then registers the updated payload with a valid bit.
//   Ports:
//     clk, rst         : clock, asynchronous active-high reset
//     flush            : synchronous discard of the held item
//     up_valid/up_ready: handshake from the previous stage (or input)
//     up_pl            : payload from the previous stage
//     dn_valid/dn_ready: handshake to the next stage (or output)
//     dn_pl            : registered payload towards the next stage
module carry_chain_stage
    import carry_chain_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int BASE  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           up_valid,
    output logic           up_ready,
    input  stage_payload_t up_pl,
    output logic           dn_valid,
    input  logic           dn_ready,
    output stage_payload_t dn_pl
);

    logic           valid_q;
    logic           load;
    logic           ripple_c;
    stage_payload_t nxt_pl;

    // The stage can take a new item when it is empty or its item leaves
    // this same cycle.
    assign load     = !valid_q || dn_ready;
    assign up_ready = load;
    assign dn_valid = valid_q;

    // NOTE: inside always_comb blocking '=' is correct; ripple_c is
    // updated and re-read within the same loop iteration.
    always_comb begin
        nxt_pl   = up_pl;
        ripple_c = up_pl.cin;
        for (int i = 0; i < SEG; i++) begin
            nxt_pl.carry[BASE+i] = ripple_c;
            ripple_c = up_pl.g[BASE+i] | (up_pl.p[BASE+i] & ripple_c);
        end
        nxt_pl.cin = ripple_c;
    end

    // NOTE: sequential state uses non-blocking '<=' so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset on purpose, not just the valid bit:
            // the last stage drives out_carry/out_cout directly and they
            // must read 0 until the first result arrives.
            dn_pl   <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= up_valid;

            // Payload only moves with a real item, so a stalled or empty
            // stage keeps its last contents (output stays stable).
            if (load && up_valid && !flush)
                dn_pl <= nxt_pl;
        end
    end

    // Width sanity: the segment must fit inside the chain and the struct.
    if (BASE + SEG > WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_seg
        $error("carry_chain_stage: segment [%0d +: %0d] outside WIDTH %0d",
               BASE, SEG, WIDTH);
    end

endmodule

// File: rtl/carry_chain_pipe.sv
// carry_chain_pipe
//   Pipelined generate/propagate carry chain with valid/ready handshakes.
//   c[0] = in_cin, c[i+1] = g[i] | (p[i] & c[i]); STAGES segments of
//   WIDTH/STAGES bits each, one segment per cycle, latency STAGES.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     flush               : synchronous discard of every in-flight item
//     in_valid/in_ready   : input handshake (in_ready low during rst/flush)
//     in_g, in_p, in_cin  : generate/propagate vectors and chain carry-in
//     out_valid/out_ready : output handshake; outputs hold while stalled
//     out_carry           : carry into each bit (out_carry[0] = in_cin)
//     out_cout            : carry out of bit WIDTH-1
module carry_chain_pipe
    import carry_chain_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_carry,
    output logic             out_cout
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_split
        $error("carry_chain_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end
    if (WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("carry_chain_pipe: WIDTH (%0d) exceeds MAX_WIDTH (%0d)",
               WIDTH, MAX_WIDTH);
    end

    // Element k is the link between stage k-1 and stage k; element 0 is
    // the block input and element STAGES the block output.
    logic           link_valid [0:STAGES];
    logic           link_ready [0:STAGES];
    stage_payload_t link_pl    [0:STAGES];

    always_comb begin
        link_pl[0]                  = '0;
        link_pl[0].g[WIDTH-1:0]     = in_g;
        link_pl[0].p[WIDTH-1:0]     = in_p;
        link_pl[0].cin              = in_cin;
    end

    assign link_valid[0]      = in_valid;
    assign link_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        carry_chain_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .BASE  (k * SEG)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (link_valid[k]),
            .up_ready (link_ready[k]),
            .up_pl    (link_pl[k]),
            .dn_valid (link_valid[k+1]),
            .dn_ready (link_ready[k+1]),
            .dn_pl    (link_pl[k+1])
        );
    end

    // Flush already blocks the stage-0 load internally; gating here keeps
    // the advertised ready honest, and rst forces it low while asserted.
    assign in_ready  = link_ready[0] && !flush && !rst;

    assign out_valid = link_valid[STAGES];
    assign out_carry = link_pl[STAGES].carry[WIDTH-1:0];
    assign out_cout  = link_pl[STAGES].cin;

endmodule

// File: tb/tb_carry_chain_pipe.sv
// tb_carry_chain_pipe
//   Directed self-checking bench for carry_chain_pipe (WIDTH=16, STAGES=4).
//   Expected values are hand-derived from the carry recurrence.
module tb_carry_chain_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_g;
    logic [15:0] in_p;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_carry;
    logic        out_cout;

    int checks   = 0;
    int failures = 0;

    carry_chain_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_g      (in_g),
        .in_p      (in_p),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_carry (out_carry),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one item, confirm it is accepted, then wait (bounded) for the
    // result and check latency and value.
    task automatic send_and_wait(input string tag, input logic [15:0] g,
                                 input logic [15:0] p, input logic cin,
                                 input logic [15:0] exp_carry,
                                 input logic exp_cout);
        int lat;
        in_valid = 1'b1;
        in_g     = g;
        in_p     = p;
        in_cin   = cin;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_carry"}, out_carry, exp_carry);
        check({tag, "_cout"}, out_cout, exp_cout);
        tick();
        check({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        int acc;
        int seen;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_g      = '0;
        in_p      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_cout", out_cout, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_carry", out_carry, 0);

        // Generate at bit 0 propagated to the top, exact latency.
        send_and_wait("gen0", 16'h0001, 16'hFFFE, 1'b0, 16'hFFFE, 1'b1);
        // Carry-in propagated through everything; then killed at bit 15.
        send_and_wait("prop_all", 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        send_and_wait("prop_7fff", 16'h0000, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0);
        // Mixed generate/propagate; carries cross the stage 1/2 boundary.
        send_and_wait("mixed", 16'h00F0, 16'h0F00, 1'b0, 16'h1FE0, 1'b0);
        // Generate at bit 3 crosses the stage 0/1 boundary at bit 4.
        send_and_wait("seg_cross", 16'h0008, 16'h00F0, 1'b0, 16'h01F0, 1'b0);

        // 8 back-to-back items: g = 1<<t, p = 0 -> carry = 1<<(t+1).
        for (int t = 0; t < 13; t++) begin
            if (t < 8) begin
                in_valid = 1'b1;
                in_g     = 16'(1) << t;
                in_p     = '0;
                in_cin   = 1'b0;
                #1;
                check($sformatf("b2b_in_ready_%0d", t), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check($sformatf("b2b_valid_%0d", t), out_valid,
                  (t >= 3 && t <= 10) ? 1 : 0);
            if (t >= 3 && t <= 10)
                check($sformatf("b2b_carry_%0d", t), out_carry,
                      32'(16'(2) << (t - 3)));
        end

        // Backpressure: out_ready low for 10 cycles with continuous input.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_g     = 16'(1) << acc;
            in_p     = '0;
            in_cin   = 1'b0;
            #1;
            check($sformatf("bp_in_ready_%0d", c), in_ready, (c < 4) ? 1 : 0);
            if (in_ready) acc++;
            tick();
            if (c >= 3) begin
                check($sformatf("bp_hold_valid_%0d", c), out_valid, 1);
                check($sformatf("bp_hold_carry_%0d", c), out_carry, 16'h0002);
                check($sformatf("bp_hold_cout_%0d", c), out_cout, 0);
            end
        end
        check("bp_accepts", acc, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp_rel_valid_%0d", k), out_valid, 1);
            check($sformatf("bp_rel_carry_%0d", k), out_carry,
                  32'(16'(2) << k));
            tick();
        end
        check("bp_rel_empty", out_valid, 0);

        // Flush with 3 items in flight plus a 4th presented.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_g     = 16'hFFFF;
            in_p     = 16'h0000;
            in_cin   = 1'b1;
            tick();
        end
        check("fl_pre_valid", out_valid, 0);
        flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("fl_none_emerged", seen, 0);

        // Reset pulse mid-stream.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_g     = 16'(1) << k;
            in_p     = '0;
            in_cin   = 1'b0;
            tick();
        end
        check("rs_pre_valid", out_valid, 1);
        check("rs_pre_carry", out_carry, 16'h0004);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_out_carry", out_carry, 0);
        check("rs_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rs_rel_in_ready", in_ready, 1);
        send_and_wait("rs_after", 16'h0001, 16'hFFFE, 1'b0, 16'hFFFE, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
